rf_dump_reader: RTL and testbench

- Read-side initiator for the 32x32 register file.
- On a start pulse it drives both register-file read ports (Read1/Read2) to fetch a contiguous register range two registers at a time.
- It streams each register value out over a valid/ready interface, with its index and a running XOR checksum.
- Used by the debug/verification path to dump architectural state after the write-side (WriteReg/RegWrite/WriteData) has run.

---
 rtl/rf_dump_reader_if.sv | 28 ++
 rtl/rf_dump_reader.sv | 152 +++++++++++++++
 tb/tb_rf_dump_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_reader_if.sv
// Read-port and output-stream bundle between rf_dump_reader and its register
// file / consumer.
interface rf_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Read1;
  logic [ADDR_W-1:0] Read2;
  logic [DATA_W-1:0] Data1;
  logic [DATA_W-1:0] Data2;
  // A word transfers on a rising edge where out_valid && out_ready. Once valid
  // is raised, out_data/out_reg stay stable and valid stays high until that
  // transfer; out_ready is ignored while out_valid is low.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_reg;

  modport master (
    output Read1, Read2, out_valid, out_data, out_reg,
    input  Data1, Data2, out_ready
  );

  modport slave (
    input  Read1, Read2, out_valid, out_data, out_reg,
    output Data1, Data2, out_ready
  );
endinterface

// File: rtl/rf_dump_reader.sv
// Dumps a contiguous register-file range two registers per fetch and streams
// each value with its index and a running XOR checksum.
module rf_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   first_reg,
  input  logic [ADDR_W-1:0]   last_reg,
  rf_dump_reader_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W:0]     word_count,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_THR  = ADDR_W'(3);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] bufa_q, bufa_d;
  logic [DATA_W-1:0] bufb_q, bufb_d;
  logic [ADDR_W-1:0] read1_q, read1_d;
  logic [ADDR_W-1:0] read2_q, read2_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [ADDR_W-1:0] ptr_p1;
  logic              out_valid_w;

  assign ptr_p1      = ptr_q + ADDR_ONE;
  assign out_valid_w = (state_q == S_SEND_A) || (state_q == S_SEND_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      last_q     <= '0;
      bufa_q     <= '0;
      bufb_q     <= '0;
      read1_q    <= '0;
      read2_q    <= '0;
      checksum_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      bufa_q     <= bufa_d;
      bufb_q     <= bufb_d;
      read1_q    <= read1_d;
      read2_q    <= read2_d;
      checksum_q <= checksum_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    bufa_d     = bufa_q;
    bufb_d     = bufb_q;
    read1_d    = read1_q;
    read2_d    = read2_q;
    checksum_d = checksum_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          checksum_d = '0;
          count_d    = '0;
          if (first_reg <= last_reg) begin
            ptr_d   = first_reg;
            last_d  = last_reg;
            // Addresses are loaded on entry so they are already valid during FETCH.
            read1_d = first_reg;
            read2_d = first_reg + ADDR_ONE;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        bufa_d  = bus.Data1;
        bufb_d  = bus.Data2;
        state_d = S_SEND_A;
      end
      S_SEND_A: begin
        if (bus.out_ready) begin
          checksum_d = checksum_q ^ bufa_q;
          count_d    = count_q + COUNT_ONE;
          state_d    = (ptr_q == last_q) ? S_DONE : S_SEND_B;
        end
      end
      S_SEND_B: begin
        if (bus.out_ready) begin
          checksum_d = checksum_q ^ bufb_q;
          count_d    = count_q + COUNT_ONE;
          if (ptr_p1 == last_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_TWO;
            read1_d = ptr_q + ADDR_TWO;
            read2_d = ptr_q + ADDR_THR;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.out_data = '0;
    bus.out_reg  = '0;
    if (state_q == S_SEND_A) begin
      bus.out_data = bufa_q;
      bus.out_reg  = ptr_q;
    end else if (state_q == S_SEND_B) begin
      bus.out_data = bufb_q;
      bus.out_reg  = ptr_p1;
    end
  end

  assign bus.Read1     = read1_q;
  assign bus.Read2     = read2_q;
  assign bus.out_valid = out_valid_w;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign checksum      = checksum_q;
  assign word_count    = count_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed and randomized dumps of a behavioural register file, checked against
// a range/XOR reference model.
module tb_rf_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_reg;
  logic [AW-1:0] last_reg;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [AW:0]   word_count;
  logic [2:0]    dbg_state;

  logic [DW-1:0] regs [32];

  int checks = 0;
  int fails  = 0;

  logic [AW+DW-1:0] exp_q[$];

  rf_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  assign bus.Data1 = regs[bus.Read1];
  assign bus.Data2 = regs[bus.Read2];

  rf_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_reg   (first_reg),
    .last_reg    (last_reg),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum),
    .word_count  (word_count),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_done"},  64'(done),          64'd0);
    check({tag, "_data"},  64'(bus.out_data),  64'd0);
    check({tag, "_reg"},   64'(bus.out_reg),   64'd0);
    check({tag, "_read1"}, 64'(bus.Read1),     64'd0);
    check({tag, "_read2"}, 64'(bus.Read2),     64'd0);
    check({tag, "_cs"},    64'(checksum),      64'd0);
    check({tag, "_wc"},    64'(word_count),    64'd0);
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  // mode 0: ready high, 1: ready toggles, 2: random ready plus stray starts
  task automatic run_dump(input int f, input int l, input int mode, input int abort_after);
    int            n, cyc, busy_cnt, fetch_cnt, hs;
    logic [DW-1:0] exp_cs;
    logic [AW-1:0] exp_r1, exp_r2;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_reg;
    logic          prev_stall, seen_done, seen_valid;
    exp_q.delete();
    exp_cs = '0;
    n = (f <= l) ? (l - f + 1) : 0;
    for (int i = f; i <= l; i++) begin
      exp_q.push_back({AW'(i), regs[i]});
      exp_cs ^= regs[i];
    end
    cyc = 0; busy_cnt = 0; fetch_cnt = 0; hs = 0;
    prev_stall = 1'b0; seen_done = 1'b0; seen_valid = 1'b0;
    prev_data = '0; prev_reg = '0;
    @(negedge clk);
    start = 1'b1; first_reg = AW'(f); last_reg = AW'(l);
    bus.out_ready = (mode == 0);
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (abort_after != 0 && hs == abort_after) begin
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        return;
      end
      if (mode == 2 && busy) begin
        start = 1'($urandom_range(0, 1));
        first_reg = AW'($urandom); last_reg = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 1) check("busy_after_start", 64'(busy), 64'd1);
      if (busy) busy_cnt++;
      if (busy && !bus.out_valid && !done) begin
        exp_r1 = AW'(f + 2 * fetch_cnt);
        exp_r2 = exp_r1 + AW'(1);
        check("fetch_read1", 64'(bus.Read1), 64'(exp_r1));
        check("fetch_read2", 64'(bus.Read2), 64'(exp_r2));
        fetch_cnt++;
      end
      if (bus.out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("first_valid_latency", 64'(cyc), 64'd2);
      end
      if (prev_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_data",  64'(bus.out_data),  64'(prev_data));
        check("stall_reg",   64'(bus.out_reg),   64'(prev_reg));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'({bus.out_reg, bus.out_data}), 64'd0);
        end else begin
          check("word", 64'({bus.out_reg, bus.out_data}), 64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        if (bus.out_ready) hs++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_reg   = bus.out_reg;
      if (done) begin
        seen_done = 1'b1;
        check("done_valid_low", 64'(bus.out_valid), 64'd0);
        check("done_cs", 64'(checksum), 64'(exp_cs));
        check("done_wc", 64'(word_count), 64'(n));
        check("done_left", 64'(exp_q.size()), 64'd0);
        check("fetch_count", 64'(fetch_cnt), 64'((n + 1) / 2));
        if (mode == 0) check("busy_cycles", 64'(busy_cnt), 64'((n + 1) / 2 + n + 1));
      end
    end
    if (!seen_done) check("timeout_no_done", 64'd0, 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("post_done", 64'(done), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
    check("hold_cs", 64'(checksum), 64'(exp_cs));
    check("hold_wc", 64'(word_count), 64'(n));
  endtask

  initial begin
    int f, l;
    reset = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    regs[5] = 32'h5555_5555;
    run_dump(5, 5, 0, 0);
    check("single_cs", 64'(checksum), 64'h5555_5555);

    regs[10] = 32'hAAAA_AAAA;
    run_dump(4, 11, 0, 0);
    check("range_cs", 64'(checksum), 64'hFFFF_FFFF);
    run_dump(4, 11, 1, 0);
    check("toggle_cs", 64'(checksum), 64'hFFFF_FFFF);

    run_dump(20, 10, 0, 0);

    randomize_regs();
    run_dump(30, 31, 0, 0);
    run_dump(31, 31, 0, 0);

    run_dump(0, 31, 2, 5);
    run_dump(0, 31, 0, 0);
    check("full_wc", 64'(word_count), 64'd32);

    for (int t = 0; t < 6; t++) begin
      randomize_regs();
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      run_dump(f, l, 2, 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
